// File: rtl/ifetch_prefetch.sv
// Prefetching instruction fetch: keeps up to DEPTH sram-like requests in
// flight and queues returned words in order for decode.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   inst_req..wdata    sram-like request channel (read-only, word size)
//   inst_rdata         response data
//   inst_addr_ok       request accepted this cycle
//   inst_data_ok       in-order response valid this cycle
//   en                 fetch enable; low stops new requests
//   redirect           flush the buffer and restart at redirect_pc
//   redirect_pc        new fetch PC (bits [1:0] ignored)
//   out_valid/ready    decode handshake
//   out_inst, out_pc   head instruction and its PC
//
// Build option IFETCH_BYPASS_EN: a kept response arriving at an empty
// buffer is forwarded to the outputs in the same cycle.
module ifetch_prefetch #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'hBFC00000,
   parameter int unsigned PHYS_BITS = 29
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_wdata,
   input  logic [31:0] inst_rdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic        en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [31:0] PMASK =
      (PHYS_BITS >= 32) ? 32'hFFFF_FFFF
                        : ((32'd1 << PHYS_BITS) - 32'd1);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [31:0]   pc;
   logic [31:0]   pc_nxt;
   logic [31:0]   ret_pc;
   logic [31:0]   target;
   logic          req_nxt;
   logic [31:0]   addr_nxt;
   // set when a held request was overtaken by a redirect
   logic          stale;
   logic          stale_nxt;

   logic [CW-1:0] count;
   logic [CW-1:0] in_flight;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count_nxt;
   logic [CW-1:0] in_flight_nxt;
   logic [CW-1:0] drop_nxt;
   logic [CW:0]   used_nxt;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];

   logic accept;
   logic drop_hit;
   logic kept;
   logic byp;
   logic buf_nonempty;
   logic buf_pop;
   logic push;
   logic credit_ok;

   function automatic logic [31:0] phys(input logic [31:0] a);
      return a & PMASK;
   endfunction

   assign inst_wr    = 1'b0;
   assign inst_size  = 2'b10;
   assign inst_wdata = 32'd0;

   assign target       = {redirect_pc[31:2], 2'b00};
   assign accept       = inst_req & inst_addr_ok;
   assign buf_nonempty = (count != '0);
   assign drop_hit     = inst_data_ok & (drop_cnt != '0);
   assign kept         = inst_data_ok & ~redirect
                       & (drop_cnt == '0);

`ifdef IFETCH_BYPASS_EN
   // rst gate keeps the outputs at reset values while rst is low
   assign byp = kept & ~buf_nonempty & rst;
`else
   assign byp = 1'b0;
`endif

   assign out_valid = buf_nonempty | byp;
   assign out_inst  = buf_nonempty ? mem_inst[rd_ptr]
                    : (byp ? inst_rdata : 32'd0);
   assign out_pc    = buf_nonempty ? mem_pc[rd_ptr]
                    : (byp ? ret_pc : 32'd0);

   assign buf_pop = buf_nonempty & out_ready & ~redirect;
   // a bypassed word taken by decode never enters the buffer
   assign push    = kept & ~(byp & out_ready);

   assign count_nxt = redirect ? '0
                    : count + CW'(push) - CW'(buf_pop);

   assign in_flight_nxt = in_flight + CW'(accept)
                        - CW'(inst_data_ok);

   // on redirect every outstanding response is stale
   assign drop_nxt = redirect ? in_flight_nxt
                   : drop_cnt - CW'(drop_hit)
                     + CW'(accept & stale);

   // credit is judged on next-cycle state so that a pop or a
   // returning response lets issue resume without a bubble
   assign used_nxt  = {1'b0, count_nxt} + {1'b0, in_flight_nxt};
   assign credit_ok = used_nxt < (CW+1)'(DEPTH);

   always_comb begin
      state_nxt = state;
      req_nxt   = inst_req;
      addr_nxt  = inst_addr;
      stale_nxt = stale;
      pc_nxt    = pc;
      if (redirect) begin
         pc_nxt = target;
      end else if (accept && !stale) begin
         pc_nxt = pc + 32'd4;
      end
      unique case (state)
         S_IDLE: begin
            if (en && !redirect && credit_ok) begin
               state_nxt = S_REQ;
               req_nxt   = 1'b1;
               addr_nxt  = phys(pc);
            end
         end
         S_REQ: begin
            if (redirect) begin
               if (accept) begin
                  state_nxt = S_IDLE;
                  req_nxt   = 1'b0;
                  stale_nxt = 1'b0;
               end else begin
                  stale_nxt = 1'b1;
               end
            end else if (accept) begin
               stale_nxt = 1'b0;
               if (en && credit_ok) begin
                  addr_nxt = phys(pc_nxt);
               end else begin
                  state_nxt = S_IDLE;
                  req_nxt   = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         inst_req  <= 1'b0;
         inst_addr <= 32'd0;
         stale     <= 1'b0;
         pc        <= RESET_PC;
         ret_pc    <= RESET_PC;
         count     <= '0;
         in_flight <= '0;
         drop_cnt  <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         state     <= state_nxt;
         inst_req  <= req_nxt;
         inst_addr <= addr_nxt;
         stale     <= stale_nxt;
         pc        <= pc_nxt;
         count     <= count_nxt;
         in_flight <= in_flight_nxt;
         drop_cnt  <= drop_nxt;
         if (redirect) begin
            ret_pc <= target;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (kept) begin
               ret_pc <= ret_pc + 32'd4;
            end
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (buf_pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= inst_rdata;
         mem_pc[wr_ptr]   <= ret_pc;
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: sram-like slave model plus an in-order
// reference of expected request addresses and decoded PCs.
module tb_ifetch_prefetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hBFC00000;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic [31:0] inst_rdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic        en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   ifetch_prefetch #(
      .DEPTH(DEPTH),
      .RESET_PC(RESET_PC),
      .PHYS_BITS(29)
   ) dut (
      .clk(clk),
      .rst(rst),
      .inst_req(inst_req),
      .inst_wr(inst_wr),
      .inst_size(inst_size),
      .inst_addr(inst_addr),
      .inst_wdata(inst_wdata),
      .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .en(en),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_inst(out_inst),
      .out_pc(out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int fails;
   int cyc;
   int aok_mode;
   int rdy_mode;
   int lat;
   int drand;
   int n_acc;
   int n_out;

   logic        rd_now;
   logic [31:0] rd_target;
   logic [31:0] sq_addr[$];
   int          sq_due[$];
   logic [31:0] exp_issue;
   logic [31:0] exp_out;
   logic        stale_pending;
   logic        prev_hold;
   logic [31:0] prev_addr;
   logic [31:0] acc_hist[$];
   logic [31:0] opc_hist[$];
   logic [31:0] oin_hist[$];

   function automatic logic [31:0] phys(input logic [31:0] a);
      return a & 32'h1FFF_FFFF;
   endfunction

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      sq_addr.delete();
      sq_due.delete();
      acc_hist.delete();
      opc_hist.delete();
      oin_hist.delete();
      exp_issue     = RESET_PC;
      exp_out       = RESET_PC;
      stale_pending = 1'b0;
      prev_hold     = 1'b0;
      prev_addr     = 32'd0;
      rd_now        = 1'b0;
   endtask

   // one clock: slave drives, then the reference follows the handshakes
   task automatic run_cycle();
      logic acc;
      logic dok;
      @(negedge clk);
      cyc++;
      redirect    = rd_now;
      redirect_pc = rd_target;
      inst_addr_ok = inst_req && (aok_mode == 0 ||
         (aok_mode == 1 && $urandom_range(0, 1) == 1));
      dok = sq_addr.size() > 0 && sq_due[0] <= cyc &&
         (drand == 0 || $urandom_range(0, 2) != 0);
      inst_data_ok = dok;
      inst_rdata   = dok ? word(sq_addr[0]) : $urandom;
      out_ready = (rdy_mode == 0) ? 1'b1 :
                  (rdy_mode == 2) ? 1'b0 :
                  1'($urandom_range(0, 1));
      #1;
      acc = inst_req && inst_addr_ok;
      if (prev_hold) begin
         tests++;
         if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin
            fails++;
            $display("FAIL hold: req=%b addr=%h required req=1 addr=%h",
                     inst_req, inst_addr, prev_addr);
         end
      end
      tests++;
      if (sq_addr.size() + int'(inst_req) > DEPTH) begin
         fails++;
         $display("FAIL credit: outstanding=%0d req=%b limit %0d",
                  sq_addr.size(), inst_req, DEPTH);
      end
      if (acc) begin
         n_acc++;
         if (stale_pending) begin
            stale_pending = 1'b0;
         end else begin
            tests++;
            if (inst_addr !== phys(exp_issue)) begin
               fails++;
               $display("FAIL req_addr: got %h required %h",
                        inst_addr, phys(exp_issue));
            end
            acc_hist.push_back(inst_addr);
            exp_issue = exp_issue + 32'd4;
         end
         sq_addr.push_back(inst_addr);
         sq_due.push_back(cyc + lat);
      end
      if (dok) begin
         void'(sq_addr.pop_front());
         void'(sq_due.pop_front());
      end
      if (!redirect && out_valid === 1'b1 && out_ready) begin
         tests++;
         n_out++;
         if (out_pc !== exp_out || out_inst !== word(phys(exp_out))) begin
            fails++;
            $display("FAIL out: pc=%h inst=%h required pc=%h inst=%h",
                     out_pc, out_inst, exp_out, word(phys(exp_out)));
         end
         opc_hist.push_back(out_pc);
         oin_hist.push_back(out_inst);
         exp_out = exp_out + 32'd4;
      end
      if (redirect) begin
         exp_issue     = {rd_target[31:2], 2'b00};
         exp_out       = {rd_target[31:2], 2'b00};
         stale_pending = inst_req && !inst_addr_ok;
         acc_hist.delete();
         opc_hist.delete();
         oin_hist.delete();
      end
      prev_hold = inst_req && !inst_addr_ok;
      prev_addr = inst_addr;
      rd_now    = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] t);
      rd_now    = 1'b1;
      rd_target = t;
      run_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'd0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata = 32'd0;
      out_ready = 1'b1;
      model_reset();
      #22;
      tests++;
      if (inst_req !== 1'b0 || inst_addr !== 32'd0) begin
         fails++;
         $display("FAIL reset_req: req=%b addr=%h required 0 0",
                  inst_req, inst_addr);
      end
      tests++;
      if (out_valid !== 1'b0 || out_inst !== 32'd0 ||
          out_pc !== 32'd0) begin
         fails++;
         $display("FAIL reset_out: v=%b inst=%h pc=%h required 0 0 0",
                  out_valid, out_inst, out_pc);
      end
      tests++;
      if (inst_wr !== 1'b0 || inst_size !== 2'b10 ||
          inst_wdata !== 32'd0) begin
         fails++;
         $display("FAIL consts: wr=%b size=%b wdata=%h required 0 10 0",
                  inst_wr, inst_size, inst_wdata);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_stream();
      int snap;
      en = 1'b1;
      aok_mode = 0;
      lat = 2;
      rdy_mode = 0;
      drand = 0;
      repeat (12) run_cycle();
      snap = n_out;
      repeat (20) run_cycle();
      tests++;
      if (n_out - snap != 20) begin
         fails++;
         $display("FAIL throughput: %0d outputs in 20 cycles required 20",
                  n_out - snap);
      end
      tests++;
      if (acc_hist.size() < 2 || acc_hist[0] !== 32'h1FC00000 ||
          acc_hist[1] !== 32'h1FC00004) begin
         fails++;
         $display("FAIL first_addrs: n=%0d required 1fc00000 1fc00004",
                  acc_hist.size());
      end
      tests++;
      if (opc_hist.size() < 1 || opc_hist[0] !== 32'hBFC00000) begin
         fails++;
         $display("FAIL first_pc: n=%0d required bfc00000",
                  opc_hist.size());
      end
   endtask

   task automatic test_full();
      int snap;
      int osnap;
      rdy_mode = 2;
      do_redirect(32'h0000_2000);
      snap = n_acc;
      repeat (15) run_cycle();
      tests++;
      if (n_acc - snap != DEPTH || inst_req !== 1'b0) begin
         fails++;
         $display("FAIL full: accepted=%0d req=%b required %0d 0",
                  n_acc - snap, inst_req, DEPTH);
      end
      osnap = n_out;
      rdy_mode = 0;
      run_cycle();
      rdy_mode = 2;
      tests++;
      if (n_out - osnap != 1) begin
         fails++;
         $display("FAIL full_pop: pops=%0d required 1", n_out - osnap);
      end
      run_cycle();
      tests++;
      if (inst_req !== 1'b1) begin
         fails++;
         $display("FAIL resume: req=%b required 1", inst_req);
      end
      repeat (10) run_cycle();
      tests++;
      if (n_acc - snap != DEPTH + 1 || inst_req !== 1'b0) begin
         fails++;
         $display("FAIL refill: accepted=%0d req=%b required %0d 0",
                  n_acc - snap, inst_req, DEPTH + 1);
      end
   endtask

   task automatic test_redirect_drop();
      int k;
      rdy_mode = 0;
      en = 1'b0;
      repeat (12) run_cycle();
      en = 1'b1;
      lat = 8;
      do_redirect(32'h0000_6000);
      k = 0;
      while (sq_addr.size() != 3 && k < 20) begin
         run_cycle();
         k++;
      end
      tests++;
      if (sq_addr.size() != 3) begin
         fails++;
         $display("FAIL inflight3: outstanding=%0d required 3",
                  sq_addr.size());
      end
      do_redirect(32'h8000_1000);
      repeat (30) run_cycle();
      tests++;
      if (opc_hist.size() < 1 || opc_hist[0] !== 32'h8000_1000 ||
          oin_hist[0] !== word(32'h0000_1000)) begin
         fails++;
         $display("FAIL drop_first: n=%0d required pc 80001000 inst %h",
                  opc_hist.size(), word(32'h0000_1000));
      end
   endtask

   task automatic test_redirect_held();
      int k;
      lat = 2;
      aok_mode = 2;
      do_redirect(32'h0000_3000);
      k = 0;
      while (inst_req !== 1'b1 && k < 10) begin
         run_cycle();
         k++;
      end
      tests++;
      if (inst_req !== 1'b1) begin
         fails++;
         $display("FAIL held_req: req=%b required 1", inst_req);
      end
      run_cycle();
      do_redirect(32'h0000_4000);
      run_cycle();
      aok_mode = 0;
      repeat (20) run_cycle();
      tests++;
      if (acc_hist.size() < 1 || acc_hist[0] !== 32'h0000_4000) begin
         fails++;
         $display("FAIL held_next: n=%0d required addr 00004000",
                  acc_hist.size());
      end
      tests++;
      if (opc_hist.size() < 1 || opc_hist[0] !== 32'h0000_4000 ||
          oin_hist[0] !== word(32'h0000_4000)) begin
         fails++;
         $display("FAIL held_out: n=%0d required pc 00004000",
                  opc_hist.size());
      end
   endtask

   task automatic test_wrap();
      do_redirect(32'hFFFF_FFF8);
      repeat (20) run_cycle();
      tests++;
      if (acc_hist.size() < 3 || acc_hist[0] !== 32'h1FFF_FFF8 ||
          acc_hist[1] !== 32'h1FFF_FFFC || acc_hist[2] !== 32'd0) begin
         fails++;
         $display("FAIL wrap_addr: n=%0d required 1ffffff8 1ffffffc 0",
                  acc_hist.size());
      end
      tests++;
      if (opc_hist.size() < 3 || opc_hist[1] !== 32'hFFFF_FFFC ||
          opc_hist[2] !== 32'd0) begin
         fails++;
         $display("FAIL wrap_pc: n=%0d required fffffffc then 0",
                  opc_hist.size());
      end
   endtask

   task automatic test_reset_mid();
      int k;
      lat = 3;
      do_redirect(32'h0000_5000);
      k = 0;
      while (sq_addr.size() != 2 && k < 20) begin
         run_cycle();
         k++;
      end
      tests++;
      if (sq_addr.size() != 2) begin
         fails++;
         $display("FAIL inflight2: outstanding=%0d required 2",
                  sq_addr.size());
      end
      #1;
      rst = 1'b0;
      #1;
      tests++;
      if (inst_req !== 1'b0 || inst_addr !== 32'd0 ||
          out_valid !== 1'b0 || out_inst !== 32'd0 ||
          out_pc !== 32'd0) begin
         fails++;
         $display("FAIL async_rst: req=%b addr=%h v=%b pc=%h required 0",
                  inst_req, inst_addr, out_valid, out_pc);
      end
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      redirect = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) run_cycle();
      tests++;
      if (acc_hist.size() < 1 || acc_hist[0] !== 32'h1FC00000 ||
          opc_hist.size() < 1 || opc_hist[0] !== RESET_PC) begin
         fails++;
         $display("FAIL post_rst: n=%0d/%0d required 1fc00000 bfc00000",
                  acc_hist.size(), opc_hist.size());
      end
   endtask

   task automatic test_random();
      int snap;
      snap = n_out;
      aok_mode = 1;
      rdy_mode = 1;
      drand = 1;
      for (int i = 0; i < 500; i++) begin
         lat = $urandom_range(1, 4);
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 24) == 0) begin
            rd_now = 1'b1;
            rd_target = $urandom;
         end
         run_cycle();
      end
      tests++;
      if (n_out - snap < 50) begin
         fails++;
         $display("FAIL random_flow: %0d outputs required at least 50",
                  n_out - snap);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc = 0;
      n_acc = 0;
      n_out = 0;
      aok_mode = 0;
      rdy_mode = 0;
      lat = 2;
      drand = 0;
      rd_target = 32'd0;
      test_reset();
      test_stream();
      test_full();
      test_redirect_drop();
      test_redirect_held();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule
